// File: rtl/pc_branch_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_branch_unit_pkg
// Shared constants for the branch-resolution path: opcode encodings of the
// control-transfer instructions and the bit positions inside the {Z,N} flag
// pair. Also imported by the writeback, forwarding and bubble-control blocks.
// -----------------------------------------------------------------------------
package pc_branch_unit_pkg;

   localparam logic [3:0] OP_BR    = 4'h9;  // unconditional branch
   localparam logic [3:0] OP_BRC   = 4'ha;  // BR.Z / BR.N, selected by brx
   localparam logic [3:0] OP_BRSUB = 4'hb;  // branch to subroutine (push link)
   localparam logic [3:0] OP_RET   = 4'hc;  // return (pop link)

   localparam int Z_BIT = 1;
   localparam int N_BIT = 0;

endpackage : pc_branch_unit_pkg

// File: rtl/pc_branch_unit_ras.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular return-address LIFO. A push writes at the pointer and advances it;
// when full, the push silently overwrites the oldest entry and sets the
// sticky overflow flag. A pop reads the entry just below the pointer and
// retreats; popping an empty stack changes nothing but the sticky underflow
// flag.
//
// Ports:
//   clk        clock, all updates on posedge
//   rst        asynchronous active-low reset
//   push       write push_data and advance
//   pop        retreat (top_data is the value being popped)
//   push_data  value to push
//   top_data   combinational view of the entry below the pointer
//   empty      count == 0
//   count      number of valid entries (0..DEPTH)
//   ovf        sticky: push while full
//   unf        sticky: pop while empty
// -----------------------------------------------------------------------------
module ras_stack #(
   parameter  int W     = 8,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  logic           pop,
   input  logic [W-1:0]   push_data,
   output logic [W-1:0]   top_data,
   output logic           empty,
   output logic [PTR_W:0] count,
   output logic           ovf,
   output logic           unf
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             ovf_reg;
   logic             unf_reg;
   logic             full;

   assign full     = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty    = (count_reg == '0);
   // DEPTH is a power of two, so pointer arithmetic wraps naturally.
   assign top_data = mem[ptr_reg - PTR_W'(1)];
   assign count    = count_reg;
   assign ovf      = ovf_reg;
   assign unf      = unf_reg;

   // Entry contents carry no reset; only the bookkeeping does.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_reg   <= '0;
         count_reg <= '0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else if (push) begin
         ptr_reg <= ptr_reg + PTR_W'(1);
         if (full) begin
            ovf_reg <= 1'b1;
         end else begin
            count_reg <= count_reg + (PTR_W+1)'(1);
         end
      end else if (pop) begin
         if (empty) begin
            unf_reg <= 1'b1;
         end else begin
            ptr_reg   <= ptr_reg - PTR_W'(1);
            count_reg <= count_reg - (PTR_W+1)'(1);
         end
      end
   end

endmodule : ras_stack

// File: rtl/pc_branch_unit.sv
// -----------------------------------------------------------------------------
// pc_branch_unit
// Program counter plus branch resolution. Decides whether the resolving
// instruction redirects fetch, selects the next PC (return > branch >
// sequential > hold), emits a one-cycle flush after every taken redirect and
// keeps subroutine return addresses in a ras_stack.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   pc_en      1 = advance sequentially, 0 = stall
//   br_valid   op/brx/zn/target/link_pc are meaningful this cycle
//   op         opcode of the resolving instruction
//   brx        conditional select: 0 = Z, 1 = N
//   zn         {Z,N} flags
//   target     branch target
//   link_pc    return address pushed by BR.SUB
//   pc         current fetch address
//   flush      one-cycle pulse following a taken redirect
//   ras_count  valid return-stack entries
//   ras_ovf    sticky return-stack overflow
//   ras_unf    sticky return-stack underflow
// -----------------------------------------------------------------------------
module pc_branch_unit
   import pc_branch_unit_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter int          RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         pc_en,
   input  logic                         br_valid,
   input  logic [3:0]                   op,
   input  logic                         brx,
   input  logic [1:0]                   zn,
   input  logic [ADDR_W-1:0]            target,
   input  logic [ADDR_W-1:0]            link_pc,
   output logic [ADDR_W-1:0]            pc,
   output logic                         flush,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_ovf,
   output logic                         ras_unf
);

   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] pc_next;
   logic              flush_reg;
   logic              taken;
   logic              do_push;
   logic              do_pop;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_empty;

   // Taken decision; nothing is taken without br_valid.
   always_comb begin
      taken   = 1'b0;
      do_push = 1'b0;
      do_pop  = 1'b0;
      if (br_valid) begin
         unique case (op)
            OP_BR:    taken = 1'b1;
            OP_BRC:   taken = brx ? zn[N_BIT] : zn[Z_BIT];
            OP_BRSUB: begin
               taken   = 1'b1;
               do_push = 1'b1;
            end
            OP_RET:   begin
               taken  = 1'b1;
               do_pop = 1'b1;
            end
            default:  taken = 1'b0;
         endcase
      end
   end

   // Next PC; a redirect always beats a stall. An empty-stack return falls
   // back to the register target.
   always_comb begin
      pc_next = pc_reg;
      if (do_pop) begin
         pc_next = ras_empty ? target : ras_top;
      end else if (taken) begin
         pc_next = target;
      end else if (pc_en) begin
         pc_next = pc_reg + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_reg    <= RESET_PC;
         flush_reg <= 1'b0;
      end else begin
         pc_reg    <= pc_next;
         flush_reg <= taken;
      end
   end

   ras_stack #(
      .W     (ADDR_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (do_push),
      .pop       (do_pop),
      .push_data (link_pc),
      .top_data  (ras_top),
      .empty     (ras_empty),
      .count     (ras_count),
      .ovf       (ras_ovf),
      .unf       (ras_unf)
   );

   assign pc    = pc_reg;
   assign flush = flush_reg;

endmodule : pc_branch_unit

// File: tb/tb_pc_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_branch_unit
// Table-driven bench: each record holds the inputs for one cycle and the
// outputs expected after the following posedge. The driver applies records on
// the negedge and queues their expectations; the monitor pops and compares
// 1 time unit after each posedge. Reset behaviour is checked by hand.
// -----------------------------------------------------------------------------
module tb_pc_branch_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pc_en = 1'b0;
   logic       br_valid = 1'b0;
   logic [3:0] op = 4'h0;
   logic       brx = 1'b0;
   logic [1:0] zn = 2'b00;
   logic [7:0] target = 8'h00;
   logic [7:0] link_pc = 8'h00;
   logic [7:0] pc;
   logic       flush;
   logic [2:0] ras_count;
   logic       ras_ovf;
   logic       ras_unf;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pc_branch_unit #(
      .ADDR_W    (8),
      .RAS_DEPTH (4),
      .RESET_PC  (8'h00)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pc_en     (pc_en),
      .br_valid  (br_valid),
      .op        (op),
      .brx       (brx),
      .zn        (zn),
      .target    (target),
      .link_pc   (link_pc),
      .pc        (pc),
      .flush     (flush),
      .ras_count (ras_count),
      .ras_ovf   (ras_ovf),
      .ras_unf   (ras_unf)
   );

   typedef struct {
      logic       pc_en;
      logic       br_valid;
      logic [3:0] op;
      logic       brx;
      logic [1:0] zn;
      logic [7:0] target;
      logic [7:0] link_pc;
      logic [7:0] e_pc;
      logic       e_flush;
      logic [2:0] e_cnt;
      logic       e_ovf;
      logic       e_unf;
   } vec_t;

   typedef struct {
      int         id;
      logic [7:0] pc;
      logic       flush;
      logic [2:0] cnt;
      logic       ovf;
      logic       unf;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[$];

   task automatic check(input string name, input int id, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s #%0d: got 0x%0h expected 0x%0h", name, id, act, exp);
      end else begin
         $display("[TB] ok %s #%0d = 0x%0h", name, id, act);
      end
   endtask

   // Scoreboard consumer: one expectation per clock edge while any are queued.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("pc",        e.id, int'(pc),        int'(e.pc));
         check("flush",     e.id, int'(flush),     int'(e.flush));
         check("ras_count", e.id, int'(ras_count), int'(e.cnt));
         check("ras_ovf",   e.id, int'(ras_ovf),   int'(e.ovf));
         check("ras_unf",   e.id, int'(ras_unf),   int'(e.unf));
      end
   end

   function automatic vec_t mk(input logic en, input logic bv, input logic [3:0] o,
                               input logic bx, input logic [1:0] f, input logic [7:0] tg,
                               input logic [7:0] lk, input logic [7:0] p, input logic fl,
                               input logic [2:0] c, input logic ov, input logic un);
      vec_t v;
      v.pc_en = en; v.br_valid = bv; v.op = o; v.brx = bx; v.zn = f;
      v.target = tg; v.link_pc = lk;
      v.e_pc = p; v.e_flush = fl; v.e_cnt = c; v.e_ovf = ov; v.e_unf = un;
      return v;
   endfunction

   task automatic apply(input vec_t v, input int id);
      exp_t e;
      @(negedge clk);
      pc_en = v.pc_en; br_valid = v.br_valid; op = v.op; brx = v.brx;
      zn = v.zn; target = v.target; link_pc = v.link_pc;
      e.id = id; e.pc = v.e_pc; e.flush = v.e_flush; e.cnt = v.e_cnt;
      e.ovf = v.e_ovf; e.unf = v.e_unf;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      pc_en = 1'b0; br_valid = 1'b0; op = 4'h0; brx = 1'b0; zn = 2'b00;
      target = 8'h00; link_pc = 8'h00;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (exp_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      //        en bv op    bx zn     tgt    lnk    pc     fl cnt ovf unf
      vecs.push_back(mk(1, 0, 4'h0, 0, 2'b00, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 4'h0, 0, 2'b00, 8'h00, 8'h00, 8'h02, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 4'h0, 0, 2'b00, 8'h00, 8'h00, 8'h03, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 4'ha, 0, 2'b10, 8'h40, 8'h00, 8'h40, 1, 0, 0, 0)); // BR.Z taken
      vecs.push_back(mk(1, 1, 4'ha, 0, 2'b00, 8'h40, 8'h00, 8'h41, 0, 0, 0, 0)); // BR.Z not
      vecs.push_back(mk(1, 1, 4'ha, 1, 2'b01, 8'h50, 8'h00, 8'h50, 1, 0, 0, 0)); // BR.N taken
      vecs.push_back(mk(1, 1, 4'ha, 1, 2'b10, 8'h60, 8'h00, 8'h51, 0, 0, 0, 0)); // BR.N not
      vecs.push_back(mk(0, 0, 4'h0, 0, 2'b00, 8'h00, 8'h00, 8'h51, 0, 0, 0, 0)); // stall
      vecs.push_back(mk(0, 0, 4'h9, 0, 2'b00, 8'h77, 8'h00, 8'h51, 0, 0, 0, 0)); // invalid op
      vecs.push_back(mk(0, 1, 4'h9, 0, 2'b00, 8'h20, 8'h00, 8'h20, 1, 0, 0, 0)); // redirect beats stall
      vecs.push_back(mk(1, 1, 4'h9, 0, 2'b00, 8'hFE, 8'h00, 8'hFE, 1, 0, 0, 0)); // back-to-back flush
      vecs.push_back(mk(1, 0, 4'h0, 0, 2'b00, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 4'h0, 0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0)); // wrap
      vecs.push_back(mk(1, 1, 4'h5, 0, 2'b11, 8'h99, 8'h00, 8'h01, 0, 0, 0, 0)); // non-branch op
      vecs.push_back(mk(0, 1, 4'hb, 0, 2'b00, 8'h80, 8'h11, 8'h80, 1, 1, 0, 0)); // calls
      vecs.push_back(mk(0, 1, 4'hb, 0, 2'b00, 8'h81, 8'h12, 8'h81, 1, 2, 0, 0));
      vecs.push_back(mk(0, 1, 4'hb, 0, 2'b00, 8'h82, 8'h13, 8'h82, 1, 3, 0, 0));
      vecs.push_back(mk(0, 1, 4'hb, 0, 2'b00, 8'h83, 8'h14, 8'h83, 1, 4, 0, 0));
      vecs.push_back(mk(0, 1, 4'hb, 0, 2'b00, 8'h84, 8'h15, 8'h84, 1, 4, 1, 0)); // overflow
      vecs.push_back(mk(0, 1, 4'hc, 0, 2'b00, 8'hAA, 8'h00, 8'h15, 1, 3, 1, 0)); // returns
      vecs.push_back(mk(0, 1, 4'hc, 0, 2'b00, 8'hAA, 8'h00, 8'h14, 1, 2, 1, 0));
      vecs.push_back(mk(0, 1, 4'hc, 0, 2'b00, 8'hAA, 8'h00, 8'h13, 1, 1, 1, 0));
      vecs.push_back(mk(0, 1, 4'hc, 0, 2'b00, 8'hAA, 8'h00, 8'h12, 1, 0, 1, 0));
      vecs.push_back(mk(0, 1, 4'hc, 0, 2'b00, 8'h33, 8'h00, 8'h33, 1, 0, 1, 1)); // underflow
      vecs.push_back(mk(1, 0, 4'hc, 0, 2'b00, 8'h44, 8'h00, 8'h34, 0, 0, 1, 1)); // ignored return

      // Reset state
      #12;
      check("rst_pc",    0, int'(pc),        0);
      check("rst_flush", 0, int'(flush),     0);
      check("rst_cnt",   0, int'(ras_count), 0);
      check("rst_ovf",   0, int'(ras_ovf),   0);
      check("rst_unf",   0, int'(ras_unf),   0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], i + 1);
      end
      idle();
      drain();

      // Async reset mid-cycle with a taken redirect pending: state clears at
      // once and the redirect never lands.
      @(negedge clk);
      pc_en = 1'b1; br_valid = 1'b1; op = 4'h9; target = 8'h55;
      #2;
      rst = 1'b0;
      #1;
      check("async_pc",    100, int'(pc),        0);
      check("async_flush", 100, int'(flush),     0);
      check("async_cnt",   100, int'(ras_count), 0);
      check("async_ovf",   100, int'(ras_ovf),   0);
      check("async_unf",   100, int'(ras_unf),   0);
      @(posedge clk);
      #1;
      check("held_pc", 101, int'(pc), 0);
      idle();
      rst = 1'b1;
      apply(mk(1, 0, 4'h0, 0, 2'b00, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0), 102);
      apply(mk(1, 1, 4'hc, 0, 2'b00, 8'h66, 8'h00, 8'h66, 1, 0, 0, 1), 103);
      idle();
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_pc_branch_unit
